// File: rtl/sine_stim_sequencer.sv
// Walks the 3-port sine ROM in LANES-sample blocks and presents each block on a
// valid/ready stream. The table can be played once or looped until abort.
module sine_stim_sequencer #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 3,
   parameter int END_ADDR   = 507
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  continuous,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data_1,
   input  logic [DATA_WIDTH-1:0] rom_data_2,
   input  logic [DATA_WIDTH-1:0] rom_data_3,
   output logic [DATA_WIDTH-1:0] out_x0,
   output logic [DATA_WIDTH-1:0] out_x1,
   output logic [DATA_WIDTH-1:0] out_x2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] block_count
);

   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(LANES);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(END_ADDR);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  loop_mode;
   logic                  load, hs, at_end, start_ok;

   assign hs       = out_valid & out_ready;
   assign at_end   = (addr == LAST);
   assign rom_addr = addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (load && at_end && !loop_mode) state_nx = DRAIN;
         DRAIN:   if (hs) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end

   always_comb begin
      busy     = (state == RUN) || (state == DRAIN);
      done     = (state == DONE);
      load     = (state == RUN) && (!out_valid || out_ready);
      start_ok = (state == IDLE) && start && !abort;
   end

   // A load in the same cycle as a handshake replaces the block, so valid stays up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr        <= '0;
         loop_mode   <= 1'b0;
         out_x0      <= '0;
         out_x1      <= '0;
         out_x2      <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         block_count <= '0;
      end else if (abort) begin
         addr      <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (start_ok) begin
            addr        <= '0;
            loop_mode   <= continuous;
            block_count <= '0;
         end
         if (load) begin
            out_x0    <= rom_data_1;
            out_x1    <= rom_data_2;
            out_x2    <= rom_data_3;
            out_valid <= 1'b1;
            out_last  <= at_end;
            addr      <= at_end ? '0 : addr + STEP;
         end else if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (hs) block_count <= block_count + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_sine_stim_sequencer.sv
// Bench for sine_stim_sequencer: identity ROM image, expected blocks queued before
// each pass and checked by a negedge monitor on every handshake.
module tb_sine_stim_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, continuous, abort, out_ready;
   logic [8:0]  rom_addr, block_count;
   logic [15:0] rom_data_1, rom_data_2, rom_data_3;
   logic [15:0] out_x0, out_x1, out_x2;
   logic        out_valid, out_last, busy, done;

   typedef struct packed {
      logic [15:0] x0, x1, x2;
      logic        last;
   } blk_t;

   blk_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_last = 0;
   logic done_seen;

   always #5 clk = ~clk;

   assign rom_data_1 = 16'(rom_addr);
   assign rom_data_2 = 16'(rom_addr) + 16'd1;
   assign rom_data_3 = 16'(rom_addr) + 16'd2;

   sine_stim_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .LANES(3), .END_ADDR(507)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
      .rom_addr(rom_addr), .rom_data_1(rom_data_1), .rom_data_2(rom_data_2),
      .rom_data_3(rom_data_3), .out_x0(out_x0), .out_x1(out_x1), .out_x2(out_x2),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done), .block_count(block_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_blocks(input int n);
      for (int k = 0; k < n; k++) begin
         int j;
         blk_t e;
         j = k % 170;
         e.x0 = 16'(3 * j);
         e.x1 = 16'(3 * j + 1);
         e.x2 = 16'(3 * j + 2);
         e.last = (j == 169);
         q.push_back(e);
      end
   endtask

   // Bounded wait, sampled on negedge: either a given lane-0 value or an out_last block.
   task automatic wait_for(input string tag, input int val, input bit want_last, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         done_seen = done_seen | done;
         if (out_valid && (want_last ? out_last : (out_x0 == 16'(val)))) found = 1'b1;
      end
      chk(tag, 64'(found), 64'd1);
   endtask

   task automatic start_pass(input logic cont);
      @(posedge clk); #1;
      start = 1'b1; continuous = cont;
      @(posedge clk); #1;
      start = 1'b0; continuous = 1'b0;
   endtask

   task automatic abort_after(input string tag, input int val);
      wait_for(tag, val, 1'b0, 400);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && !abort && out_valid && out_ready) begin
         chk("blk_avail", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) chk("blk", 64'({out_x0, out_x1, out_x2, out_last}), 64'(q.pop_front()));
         if (out_last) n_last++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; out_ready = 1'b1;
      done_seen = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_outs", 64'({rom_addr, out_x0, out_x1, out_x2, out_valid, out_last, busy, done}), 64'd0);
      chk("rst_count", 64'(block_count), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // start together with abort from IDLE must be ignored
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("start_abort_valid", 64'(out_valid), 64'd0);

      // single pass: latency, start-while-busy, backpressure on {30,31,32}, done
      push_blocks(170);
      @(posedge clk); #1;
      start = 1'b1; continuous = 1'b0;
      @(negedge clk);
      chk("lat_c0", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      start = 1'b1; continuous = 1'b1;
      @(negedge clk);
      chk("lat_c1", 64'(out_valid), 64'd0);
      chk("busy_c1", 64'(busy), 64'd1);
      @(posedge clk); #1;
      start = 1'b0; continuous = 1'b0;
      @(negedge clk);
      chk("lat_c2", 64'({out_valid, out_x0}), 64'({1'b1, 16'd0}));
      wait_for("reach_27", 27, 1'b0, 50);
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_blk", 64'({out_valid, out_x0, out_x1, out_x2}), 64'({1'b1, 16'd30, 16'd31, 16'd32}));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_for("reach_last", 0, 1'b1, 300);
      chk("last_x0", 64'(out_x0), 64'd507);
      @(negedge clk);
      chk("done_pulse", 64'({done, busy, out_valid}), 64'({1'b1, 1'b0, 1'b0}));
      chk("pass_count", 64'(block_count), 64'd170);
      chk("pass_drained", 64'(q.size()), 64'd0);
      @(negedge clk);
      chk("done_clear", 64'(done), 64'd0);

      // loop mode over three passes, then abort
      push_blocks(511);
      n_last = 0;
      done_seen = 1'b0;
      start_pass(1'b1);
      for (int p = 0; p < 3; p++) wait_for("loop_last", 0, 1'b1, 300);
      wait_for("loop_wrap", 0, 1'b0, 5);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("loop_no_done", 64'(done_seen), 64'd0);
      chk("loop_lasts", 64'(n_last), 64'd3);
      chk("loop_abort_state", 64'({out_valid, out_last, busy, done, rom_addr}), 64'd0);
      chk("loop_count", 64'(block_count), 64'd511);
      chk("loop_drained", 64'(q.size()), 64'd0);

      // single-pass abort while {90,91,92} is offered
      push_blocks(30);
      done_seen = 1'b0;
      start_pass(1'b0);
      abort_after("reach_87", 87);
      chk("abort_state", 64'({out_valid, out_last, busy, done}), 64'd0);
      chk("abort_count", 64'(block_count), 64'd30);
      chk("abort_drained", 64'(q.size()), 64'd0);
      @(negedge clk);
      chk("abort_no_done", 64'(done | done_seen), 64'd0);

      // asynchronous reset mid-pass, then clean restart
      push_blocks(170);
      start_pass(1'b0);
      wait_for("reach_60", 60, 1'b0, 50);
      #2 rst = 1'b1;
      #1;
      chk("arst_outs", 64'({rom_addr, out_x0, out_x1, out_x2, out_valid, out_last, busy, done}), 64'd0);
      chk("arst_count", 64'(block_count), 64'd0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      push_blocks(3);
      start_pass(1'b0);
      abort_after("restart_6", 6);
      chk("restart_count", 64'(block_count), 64'd3);
      chk("restart_drained", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
